// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcode/funct constants and select encodings for mc_ctrl
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11
    } state_e;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - maps operation class and funct field to the 3-bit ALU function code
module mc_alu_dec
    import mc_pkg::*;
#(
    parameter int FNW = 6
) (
    input  aluop_e         i_op,
    input  logic [FNW-1:0] i_funct,
    output logic [2:0]     o_alu_func,
    output logic           o_funct_illegal
);

    logic [2:0] funct_func;

    // The legality flag depends only on funct so DECODE can use it before EXEC.
    always_comb begin
        funct_func      = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  funct_func = ALU_ADD;
            FN_SUB:  funct_func = ALU_SUB;
            FN_AND:  funct_func = ALU_AND;
            FN_OR:   funct_func = ALU_OR;
            FN_SLT:  funct_func = ALU_SLT;
            default: o_funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_func = ALU_ADD;
        case (i_op)
            ALUOP_ADD:   o_alu_func = ALU_ADD;
            ALUOP_SUB:   o_alu_func = ALU_SUB;
            ALUOP_FUNCT: o_alu_func = funct_func;
            default:     o_alu_func = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM; MC_CTRL_BNE_EN adds bne support
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [OPW-1:0] i_opcode,
    input  logic [FNW-1:0] i_funct,
    input  logic           i_alu_zero,
    output logic [2:0]     o_alu_func,
    output logic           o_alu_src_a,
    output logic [1:0]     o_alu_src_b,
    output logic [1:0]     o_pc_src,
    output logic           o_pc_en,
    output logic           o_iord,
    output logic           o_mem_we,
    output logic           o_ir_we,
    output logic           o_reg_dst,
    output logic           o_mem_to_reg,
    output logic           o_reg_we,
    output logic           o_illegal
);

    state_e state_q, state_d;
    aluop_e alu_op;
    logic   funct_illegal;
    logic   pc_write;
    logic   branch;
    logic   branch_cond;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MC_CTRL_BNE_EN
    logic is_bne_q, is_bne_d;

    // Remembers which branch flavour was decoded so BRANCH can pick the condition.
    always_comb begin
        is_bne_d = is_bne_q;
        if (state_q == ST_DECODE) begin
            is_bne_d = (i_opcode == OP_BNE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            is_bne_q <= 1'b0;
        end else begin
            is_bne_q <= is_bne_d;
        end
    end

    assign branch_cond = is_bne_q ? ~i_alu_zero : i_alu_zero;
`else
    assign branch_cond = i_alu_zero;
`endif

    mc_alu_dec #(
        .FNW(FNW)
    ) u_alu_dec (
        .i_op            (alu_op),
        .i_funct         (i_funct),
        .o_alu_func      (o_alu_func),
        .o_funct_illegal (funct_illegal)
    );

    always_comb begin
        state_d      = ST_FETCH;
        alu_op       = ALUOP_ADD;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_B;
        o_pc_src     = PCSRC_ALU;
        pc_write     = 1'b0;
        branch       = 1'b0;
        o_iord       = 1'b0;
        o_mem_we     = 1'b0;
        o_ir_we      = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_we     = 1'b0;
        o_illegal    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                o_ir_we     = 1'b1;
                pc_write    = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                state_d     = ST_DECODE;
            end
            ST_DECODE: begin
                // The ALU precomputes the branch target while the opcode is decoded.
                o_alu_src_b = SRCB_IMMSH;
                case (i_opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE: begin
                        if (funct_illegal) begin
                            o_illegal = 1'b1;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d   = ST_EXEC;
                        end
                    end
                    OP_BEQ:  state_d = ST_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  state_d = ST_BRANCH;
`else
                    OP_BNE: begin
                        o_illegal = 1'b1;
                        state_d   = ST_FETCH;
                    end
`endif
                    OP_ADDI: state_d = ST_ADDIEX;
                    OP_J:    state_d = ST_JUMP;
                    default: begin
                        o_illegal = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                state_d     = (i_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                o_iord  = 1'b1;
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_MEMWR: begin
                o_iord   = 1'b1;
                o_mem_we = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_EXEC: begin
                o_alu_src_a = 1'b1;
                alu_op      = ALUOP_FUNCT;
                state_d     = ST_ALUWB;
            end
            ST_ALUWB: begin
                o_reg_we  = 1'b1;
                o_reg_dst = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                o_alu_src_a = 1'b1;
                alu_op      = ALUOP_SUB;
                o_pc_src    = PCSRC_ALUOUT;
                branch      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                state_d     = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                o_reg_we = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_JUMP: begin
                o_pc_src = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign o_pc_en = pc_write | (branch & branch_cond);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic [2:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, illegal;

    int checks   = 0;
    int failures = 0;

    mc_ctrl dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_alu_zero   (alu_zero),
        .o_alu_func   (alu_func),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_pc_src     (pc_src),
        .o_pc_en      (pc_en),
        .o_iord       (iord),
        .o_mem_we     (mem_we),
        .o_ir_we      (ir_we),
        .o_reg_dst    (reg_dst),
        .o_mem_to_reg (mem_to_reg),
        .o_reg_we     (reg_we),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    // {func, src_a, src_b, pc_src, pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, illegal}
    logic [15:0] obs;
    assign obs = {alu_func, alu_src_a, alu_src_b, pc_src,
                  pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, illegal};

    localparam logic [15:0] E_FETCH  = {3'b010, 1'b0, 2'b01, 2'b00, 8'b1001_0000};
    localparam logic [15:0] E_DECODE = {3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
    localparam logic [15:0] E_DECILL = {3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0001};
    localparam logic [15:0] E_MEMADR = {3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [15:0] E_MEMRD  = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0100_0000};
    localparam logic [15:0] E_MEMWB  = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_0110};
    localparam logic [15:0] E_MEMWR  = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0110_0000};
    localparam logic [15:0] E_ALUWB  = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_1010};
    localparam logic [15:0] E_ADDIEX = {3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [15:0] E_ADDIWB = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_0010};
    localparam logic [15:0] E_JUMP   = {3'b010, 1'b0, 2'b00, 2'b10, 8'b1000_0000};
    localparam logic [15:0] E_BR_TK  = {3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000};
    localparam logic [15:0] E_BR_NT  = {3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        opcode   = 6'b000000;
        funct    = 6'b100000;
        alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("FAIL reset_values got=%h expected=%h", obs, E_FETCH);
        end
        rstn = 1'b1;
    endtask

    task automatic test_lw();
        logic [15:0] exp [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL lw cycle=%0d got=%h expected=%h", i + 1, obs, exp[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_sw();
        logic [15:0] exp [5] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL sw cycle=%0d got=%h expected=%h", i + 1, obs, exp[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] al_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [15:0] exp [5];
        opcode = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            funct = fn_tab[k];
            exp = '{E_FETCH, E_DECODE, {al_tab[k], 1'b1, 2'b00, 2'b00, 8'b0000_0000},
                    E_ALUWB, E_FETCH};
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL rtype funct=%b cycle=%0d got=%h expected=%h",
                             fn_tab[k], i + 1, obs, exp[i]);
                end
                if (i < 4) step();
            end
        end
        funct = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== ((i == 1) ? E_DECILL : E_FETCH)) begin
                failures++;
                $display("FAIL rtype_illegal cycle=%0d got=%h expected=%h", i + 1, obs,
                         (i == 1) ? E_DECILL : E_FETCH);
            end
            if (i < 2) step();
        end
        funct = 6'b100000;
    endtask

    task automatic test_beq();
        logic [15:0] exp [4];
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            alu_zero = (z == 1);
            exp = '{E_FETCH, E_DECODE, (z == 1) ? E_BR_TK : E_BR_NT, E_FETCH};
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL beq zero=%0d cycle=%0d got=%h expected=%h", z, i + 1, obs, exp[i]);
                end
                if (i < 3) step();
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_bne();
        logic [15:0] exp [4];
        opcode = 6'b000101;
        for (int z = 1; z >= 0; z--) begin
            alu_zero = (z == 1);
`ifdef MC_CTRL_BNE_EN
            exp = '{E_FETCH, E_DECODE, (z == 1) ? E_BR_NT : E_BR_TK, E_FETCH};
            for (int i = 0; i < 4; i++) begin
`else
            exp = '{E_FETCH, E_DECILL, E_FETCH, E_FETCH};
            for (int i = 0; i < 3; i++) begin
`endif
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL bne zero=%0d cycle=%0d got=%h expected=%h", z, i + 1, obs, exp[i]);
                end
`ifdef MC_CTRL_BNE_EN
                if (i < 3) step();
`else
                if (i < 2) step();
`endif
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_j_addi();
        logic [15:0] exp_j [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        logic [15:0] exp_a [5] = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_j[i]) begin
                failures++;
                $display("FAIL j cycle=%0d got=%h expected=%h", i + 1, obs, exp_j[i]);
            end
            if (i < 3) step();
        end
        opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp_a[i]) begin
                failures++;
                $display("FAIL addi cycle=%0d got=%h expected=%h", i + 1, obs, exp_a[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_illegal_op();
        opcode = 6'b111111;
        step();
        checks++;
        if (obs !== E_DECILL) begin
            failures++;
            $display("FAIL illegal_op decode got=%h expected=%h", obs, E_DECILL);
        end
        step();
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("FAIL illegal_op return got=%h expected=%h", obs, E_FETCH);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        repeat (3) step();
        checks++;
        if (obs !== E_MEMRD) begin
            failures++;
            $display("FAIL reset_mid memrd got=%h expected=%h", obs, E_MEMRD);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("FAIL reset_mid async got=%h expected=%h", obs, E_FETCH);
        end
        @(negedge clk);
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("FAIL reset_mid held got=%h expected=%h", obs, E_FETCH);
        end
        rstn   = 1'b1;
        opcode = 6'b111111;
        step();
        checks++;
        if (obs !== E_DECILL) begin
            failures++;
            $display("FAIL reset_mid after got=%h expected=%h", obs, E_DECILL);
        end
        step();
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("FAIL reset_mid return got=%h expected=%h", obs, E_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_bne();
        test_j_addi();
        test_illegal_op();
        test_reset_mid();
        test_lw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
